lsu_wb: RTL and testbench

- Load/store and writeback stage directly upstream of the register file.
- Accepts one retired-EXU result at a time and drives the register file's write port (wen, waddr, wdata).
- Loads and stores run a request/response handshake to data memory; loads sign- or zero-extend the returned data before writeback.
- Exposes busy and pending-rd so decode can stall on a read-after-write hazard.

---
 rtl/lsu_wb_pkg.sv | 35 +++
 rtl/lsu_align.sv | 42 ++++
 rtl/lsu_wb.sv | 151 +++++++++++++++
 tb/tb_lsu_wb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the load/store + writeback stage.
package lsu_wb_pkg;

    typedef enum logic [1:0] {StIdle, StMreq, StMresp, StWb} state_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    localparam logic [3:0] MaskByte = 4'b0001;
    localparam logic [3:0] MaskHalf = 4'b0011;
    localparam logic [3:0] MaskWord = 4'b1111;

    // Unlisted funct3 codes behave as word accesses, matching lsu_align.
    function automatic logic access_misaligned(input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic half;
        logic word;
        if (is_store) begin
            half = (funct3 == F3Sh);
            word = !((funct3 == F3Sb) || half);
        end else begin
            half = (funct3 == F3Lh) || (funct3 == F3Lhu);
            word = !((funct3 == F3Lb) || (funct3 == F3Lbu) || half);
        end
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane replicate + mask, load extract + extend.
module lsu_align
    import lsu_wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wmask,
    output logic [31:0] ld_value
);

    logic [31:0] shifted;

    assign shifted = data >> {addr_lo, 3'b000};

    always_comb begin
        st_wdata = data;
        st_wmask = MaskWord;
        case (funct3)
            F3Sb: begin
                st_wdata = {4{data[7:0]}};
                st_wmask = MaskByte << addr_lo;
            end
            F3Sh: begin
                st_wdata = {2{data[15:0]}};
                st_wmask = MaskHalf << addr_lo;
            end
            default: ;
        endcase

        ld_value = shifted;
        case (funct3)
            F3Lb:  ld_value = {{24{shifted[7]}}, shifted[7:0]};
            F3Lh:  ld_value = {{16{shifted[15]}}, shifted[15:0]};
            F3Lbu: ld_value = {24'b0, shifted[7:0]};
            F3Lhu: ld_value = {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Load/store and writeback stage feeding the register file write port.
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rf_wen,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [MEM_AW-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] pending_rd,
    output logic                  misalign_err
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rf_wen_q;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;

    logic                  accept;
    logic                  mem_op;
    logic                  misaligned;
    logic [MEM_AW-1:0]     addr_full;
    logic [2:0]            al_funct3;
    logic [1:0]            al_addr_lo;
    logic [DATA_WIDTH-1:0] al_data;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [3:0]            st_wmask;
    logic [DATA_WIDTH-1:0] ld_value;

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign pending_rd = (busy && rf_wen_q) ? rd_q : '0;

    assign accept     = in_valid && in_ready;
    assign mem_op     = in_is_load || in_is_store;
    assign misaligned = mem_op && access_misaligned(in_is_store, in_funct3, in_result[1:0]);
    assign addr_full  = MEM_AW'(in_result);

    // One aligner: store steering from live inputs in IDLE, load extraction from latched
    // access info while waiting for the response.
    assign al_funct3  = in_ready ? in_funct3 : funct3_q;
    assign al_addr_lo = in_ready ? in_result[1:0] : addr_lo_q;
    assign al_data    = in_ready ? in_store_data : mem_resp_rdata;

    lsu_align u_align (
        .funct3   (al_funct3),
        .addr_lo  (al_addr_lo),
        .data     (al_data),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_value (ld_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rd_q          <= '0;
            rf_wen_q      <= 1'b0;
            is_load_q     <= 1'b0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        rd_q      <= in_rd;
                        rf_wen_q  <= in_rf_wen;
                        is_load_q <= in_is_load;
                        funct3_q  <= in_funct3;
                        addr_lo_q <= in_result[1:0];
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else if (mem_op) begin
                            state_q       <= StMreq;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= addr_full & ~MEM_AW'(3);
                            mem_req_wen   <= in_is_store;
                            mem_req_wdata <= in_is_store ? st_wdata : '0;
                            mem_req_wmask <= in_is_store ? st_wmask : 4'b0000;
                        end else begin
                            state_q  <= StWb;
                            rf_wen   <= in_rf_wen && (in_rd != '0);
                            rf_waddr <= in_rd;
                            rf_wdata <= in_result;
                        end
                    end
                end
                StMreq: begin
                    if (mem_req_ready) begin
                        state_q       <= StMresp;
                        mem_req_valid <= 1'b0;
                    end
                end
                StMresp: begin
                    if (mem_resp_valid) begin
                        if (is_load_q) begin
                            state_q  <= StWb;
                            rf_wen   <= rf_wen_q && (rd_q != '0);
                            rf_waddr <= rd_q;
                            rf_wdata <= ld_value;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StWb: begin
                    state_q  <= StIdle;
                    rf_wen   <= 1'b0;
                    rf_waddr <= '0;
                    rf_wdata <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: driver pushes expected events, monitor pops and compares.
module tb_lsu_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_rf_wen, in_is_load, in_is_store;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [31:0] in_result, in_store_data;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [3:0]  mem_req_wmask;
    logic        rf_wen, busy, misalign_err;
    logic [4:0]  rf_waddr, pending_rd;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    lsu_wb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_rf_wen      (in_rf_wen),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_result      (in_result),
        .in_store_data  (in_store_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy),
        .pending_rd     (pending_rd),
        .misalign_err   (misalign_err)
    );

    localparam int KReq = 0;
    localparam int KWb  = 1;
    localparam int KErr = 2;
    localparam int OpAlu = 0;
    localparam int OpLoad = 1;
    localparam int OpStore = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access size in bytes from the architectural funct3 meaning.
    function automatic int size_of(input bit is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3, input int lane,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int          sz;
        v  = rdata >> (8 * lane);
        sz = size_of(1'b0, f3);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic recover();
        in_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    // Issues one instruction and plays the memory side; returns 1ns after the last edge it drove.
    task automatic do_txn(input int op, input logic [4:0] rd, input logic wen,
                          input logic [2:0] f3, input logic [31:0] res,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int req_dly, input int resp_dly);
        int   budget;
        int   sz;
        int   lane;
        int   m;
        bit   mis;
        exp_t e;
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
            recover();
            return;
        end
        sz   = size_of(op == OpStore, f3);
        lane = int'(res % 4);
        mis  = (op != OpAlu) && ((res % sz) != 0);
        e = '{kind: KReq, addr: res - (res % 4), wen: (op == OpStore),
              wdata: 32'h0, wmask: 4'h0, rd: rd, val: 32'h0};
        if (mis) begin
            e.kind = KErr;
            q.push_back(e);
        end else if (op == OpAlu) begin
            if (wen && rd != 0) begin
                e.kind = KWb;
                e.val  = res;
                q.push_back(e);
            end
        end else begin
            if (op == OpStore) begin
                m = ((1 << sz) - 1) << lane;
                e.wmask = m[3:0];
                e.wdata = (sz == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                          (sz == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
            end
            q.push_back(e);
            if (op == OpLoad && wen && rd != 0) begin
                e.kind = KWb;
                e.val  = load_model(f3, lane, rdata);
                q.push_back(e);
            end
        end
        in_valid      = 1'b1;
        in_rd         = rd;
        in_rf_wen     = wen;
        in_is_load    = (op == OpLoad);
        in_is_store   = (op == OpStore);
        in_funct3     = f3;
        in_result     = res;
        in_store_data = sdata;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (mis || op == OpAlu) return;
        repeat (req_dly) begin
            @(posedge clk);
            #1;
        end
        if (!mem_req_valid) begin
            check("mem_req_valid_missing", mem_req_valid, 1);
            recover();
            return;
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        repeat (resp_dly) begin
            @(posedge clk);
            #1;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
    endtask

    // Monitor: every DUT-presented event consumes one scoreboard entry.
    initial begin
        exp_t        e;
        bit          prev_wait;
        logic [31:0] s_addr, s_wdata;
        logic        s_wen;
        logic [3:0]  s_wmask;
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wait = 1'b0;
                continue;
            end
            if (prev_wait && mem_req_valid) begin
                check("req_addr_stable", mem_req_addr, s_addr);
                check("req_wen_stable", {31'b0, mem_req_wen}, {31'b0, s_wen});
                check("req_wdata_stable", mem_req_wdata, s_wdata);
                check("req_wmask_stable", {28'b0, mem_req_wmask}, {28'b0, s_wmask});
            end
            prev_wait = mem_req_valid && !mem_req_ready;
            s_addr = mem_req_addr;
            s_wen = mem_req_wen;
            s_wdata = mem_req_wdata;
            s_wmask = mem_req_wmask;
            if (mem_req_valid && mem_req_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_mem_req", {31'b0, mem_req_valid}, 0);
                end else begin
                    e = q.pop_front();
                    check("req_kind", KReq, e.kind);
                    check("req_addr", mem_req_addr, e.addr);
                    check("req_wen", {31'b0, mem_req_wen}, {31'b0, e.wen});
                    if (e.wen) begin
                        check("req_wdata", mem_req_wdata, e.wdata);
                        check("req_wmask", {28'b0, mem_req_wmask}, {28'b0, e.wmask});
                    end
                end
            end
            if (rf_wen) begin
                if (q.size() == 0) begin
                    check("unexpected_rf_wen", {31'b0, rf_wen}, 0);
                end else begin
                    e = q.pop_front();
                    check("wb_kind", KWb, e.kind);
                    check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.rd});
                    check("rf_wdata", rf_wdata, e.val);
                end
            end
            if (misalign_err) begin
                if (q.size() == 0) begin
                    check("unexpected_misalign", {31'b0, misalign_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("err_kind", KErr, e.kind);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        logic [2:0]  f3;
        logic [31:0] res;
        int          sz;
        exp_t        e;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_rd = '0;
        in_rf_wen = 1'b0;
        in_is_load = 1'b0;
        in_is_store = 1'b0;
        in_funct3 = '0;
        in_result = '0;
        in_store_data = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rf_wen", {31'b0, rf_wen}, 0);
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        check("rst_pending_rd", {27'b0, pending_rd}, 0);
        check("rst_misalign_err", {31'b0, misalign_err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU writeback, one-cycle latency
        do_txn(OpAlu, 5'd5, 1'b1, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
        check("alu_rf_wen", {31'b0, rf_wen}, 1);
        check("alu_wdata", rf_wdata, 32'h1234_5678);
        check("alu_in_ready_low", {31'b0, in_ready}, 0);
        check("alu_pending_rd", {27'b0, pending_rd}, 5);
        @(posedge clk);
        #1;
        check("alu_in_ready_back", {31'b0, in_ready}, 1);

        // x0 writes dropped
        do_txn(OpAlu, 5'd0, 1'b1, 3'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 0, 0);
        check("x0_rf_wen", {31'b0, rf_wen}, 0);
        check("x0_pending_rd", {27'b0, pending_rd}, 0);

        // LB / LBU at lane 3 with a delayed ready
        do_txn(OpLoad, 5'd7, 1'b1, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2, 0);
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        do_txn(OpLoad, 5'd8, 1'b1, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2, 1);
        check("lbu_wdata", rf_wdata, 32'h0000_0080);

        // SH at lane 2
        do_txn(OpStore, 5'd0, 1'b0, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 1, 1);
        check("sh_busy_after_ack", {31'b0, busy}, 0);
        check("sh_rf_wen", {31'b0, rf_wen}, 0);

        // Misaligned LW
        do_txn(OpLoad, 5'd9, 1'b1, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0);
        check("mis_err_pulse", {31'b0, misalign_err}, 1);
        check("mis_no_req", {31'b0, mem_req_valid}, 0);
        check("mis_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        check("mis_err_one_cycle", {31'b0, misalign_err}, 0);

        // Reset while waiting for a load response, then a late response
        e = '{kind: KReq, addr: 32'h0000_0100, wen: 1'b0, wdata: 32'h0, wmask: 4'h0,
              rd: 5'd3, val: 32'h0};
        q.push_back(e);
        in_valid = 1'b1;
        in_rd = 5'd3;
        in_rf_wen = 1'b1;
        in_is_load = 1'b1;
        in_is_store = 1'b0;
        in_funct3 = 3'b010;
        in_result = 32'h0000_0100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        check("mresp_busy", {31'b0, busy}, 1);
        check("mresp_pending_rd", {27'b0, pending_rd}, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        check("late_resp_busy", {31'b0, busy}, 0);
        check("late_resp_rf_wen", {31'b0, rf_wen}, 0);
        do_txn(OpAlu, 5'd12, 1'b1, 3'd0, 32'h0BAD_C0DE, 32'h0, 32'h0, 0, 0);
        check("post_rst_alu_wen", {31'b0, rf_wen}, 1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 2);
            f3 = (op == OpStore) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            res = $urandom;
            sz = size_of(op == OpStore, f3);
            if ($urandom_range(0, 3) != 0) res = res - (res % sz);
            do_txn(op, 5'($urandom), (op == OpStore) ? 1'b0 : ($urandom_range(0, 3) != 0),
                   f3, res, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
